wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the execute-stage result interface (regcData / regcAddr / regcWr): EX/WB pipeline latch plus 32-entry general register file.
- Latches each EX result, commits it to the register array one cycle later.
- Serves two operand read ports to the decode stage, with bypass from both the in-flight EX result and the latched WB result.
- Counts committed writes for debug/performance.

Parameters:
- DATA_W, 32 (`REG_LENGTH): register/data width.
- ADDR_W, 5 (`REG_ADDR_LEN): register address width; depth = 2**ADDR_W.
- CNT_W, 32: width of committed-write counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-low.
- stall  in  1  hold EX/WB latch contents.
- flush  in  1  kill the value being latched (latch loads with wr=0).
- regcData  in  DATA_W  EX result data.
- regcAddr  in  ADDR_W  EX destination register.
- regcWr  in  1  EX destination write enable.
- regaRd  in  1  read enable, port A.
- regaAddr  in  ADDR_W  read address, port A.
- regbRd  in  1  read enable, port B.
- regbAddr  in  ADDR_W  read address, port B.
- regaData  out  DATA_W  port A read data (combinational).
- regbData  out  DATA_W  port B read data (combinational).
- wbData  out  DATA_W  latched WB data.
- wbAddr  out  ADDR_W  latched WB address.
- wbWr  out  1  latched WB write enable.
- wbCnt  out  CNT_W  committed-write count.

Behaviour:
- Reset (rst==0 at posedge):
  - wbData=0, wbAddr=0, wbWr=0, wbCnt=0.
  - All 32 array entries cleared to 0.
  - A pending latched write is discarded, not committed.
  - Reset overrides stall and flush.
- Latch, rst==1:
  - stall==1: hold wbData/wbAddr/wbWr.
  - else flush==1: wbWr<=0; wbData/wbAddr load inputs (don't-care content).
  - else: load regcData, regcAddr, regcWr.
  - stall has priority over flush.
- Commit, each posedge with rst==1:
  - If wbWr==1 and wbAddr!=0: array[wbAddr]<=wbData and wbCnt<=wbCnt+1.
  - Commit is independent of stall, and happens once per held cycle. Rewriting the same value is idempotent. wbCnt counts every commit cycle, including repeats under stall.
  - wbCnt wraps 2**CNT_W-1 -> 0 silently.
- Writes to register 0 are never stored and never counted; register 0 always reads 0.
- Latency: EX result at edge N is latched at N, committed at N+1, readable from the array after N+1. The bypass makes it visible in the same cycle it appears on the regc* inputs.
- Read port X (A or B), combinational priority:
  1. rd==0 -> 0.
  2. addr==0 -> 0.
  3. regcWr==1 and regcAddr==addr -> regcData (youngest).
  4. wbWr==1 and wbAddr==addr -> wbData.
  5. Otherwise array[addr].
- The bypass from regc* applies even when stall or flush is asserted; the upstream stage owns hazard control.
- Both ports may read the same address simultaneously; identical results.
- No X propagation: all outputs are defined after the first reset edge.

Decomposition:
- Shared header MIPS.vh supplies `REG_LENGTH, `REG_ADDR_LEN, `ENABLE, `DISABLE. Add a macro `REG_NUM (32) there.
- One natural sub-module: regfile_array. It holds the storage, clear-on-reset, one synchronous write port (with the addr!=0 guard) and two asynchronous read ports.
- wb_regfile keeps the latch, bypass muxes and counter.

Test Plan:
- Reset: hold rst=0 two cycles after writing r5=0x1234 -> reads of r5 return 0; wbWr=0; wbCnt=0.
- Basic commit: regcWr=1, regcAddr=3, regcData=0xDEADBEEF for one cycle, then idle -> regaAddr=3 returns 0xDEADBEEF in the same cycle (EX bypass), the next cycle (WB bypass) and thereafter (array); wbCnt=1.
- Bypass priority: WB latch holds r7=0x11, EX presents r7=0x22 -> regbData=0x22; the next cycle, with EX idle, it is 0x22 from WB.
- Register zero: EX writes r0=0xFFFFFFFF -> regaData for addr 0 stays 0; wbCnt unchanged.
- Stall/flush: stall=1 with latch holding r4=0x55 for 3 cycles -> latch unchanged, wbCnt+=3. flush=1 with EX r9=0x99 -> wbWr=0 next cycle, r9 never written.
- Counter wrap / reset mid-op: preload wbCnt to 0xFFFFFFFF (force), commit once -> 0. Latch r6=0x66, then rst=0 on the commit edge -> r6 reads 0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared widths and read-source selection for the writeback stage and register file.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
`ifndef REG_LENGTH
`define REG_LENGTH 32
`endif
`ifndef REG_ADDR_LEN
`define REG_ADDR_LEN 5
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef ENABLE
`define ENABLE 1'b1
`endif
`ifndef DISABLE
`define DISABLE 1'b0
`endif

package wb_regfile_pkg;

  localparam int DATA_W_DEF = `REG_LENGTH;
  localparam int ADDR_W_DEF = `REG_ADDR_LEN;
  localparam int REG_NUM_DEF = `REG_NUM;
  localparam int CNT_W_DEF = 32;

  // Where an operand read is served from, youngest producer first.
  typedef enum logic [1:0] {
    SRC_ZERO = 2'd0,
    SRC_EX   = 2'd1,
    SRC_WB   = 2'd2,
    SRC_ARR  = 2'd3
  } rd_src_t;

  // Read priority: disabled or r0 -> zero, then EX result, then WB latch, then storage.
  function automatic rd_src_t sel_src(input logic rd, input logic addr_zero,
                                      input logic ex_hit, input logic wb_hit);
    if (!rd || addr_zero) return SRC_ZERO;
    if (ex_hit)           return SRC_EX;
    if (wb_hit)           return SRC_WB;
    return SRC_ARR;
  endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// General register storage: one synchronous write port, two asynchronous read ports.
// Latency: write visible on the read ports the cycle after the write edge; reads are combinational.
// Backpressure: none; r0 is never written so it always reads zero.
import wb_regfile_pkg::*;

module wb_regfile_array #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear everything on reset; otherwise store the write unless it targets r0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read ports.
  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/wb_regfile.sv
// EX/WB latch, register file commit, bypassed operand reads and commit counter.
// Latency: EX result latched at edge N, committed at N+1; bypass makes it readable the same cycle.
// Backpressure: stall holds the latch (which re-commits each held cycle); flush kills the latched write.
import wb_regfile_pkg::*;

module wb_regfile #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [DATA_W-1:0] regcData,
  input  logic [ADDR_W-1:0] regcAddr,
  input  logic              regcWr,
  input  logic              regaRd,
  input  logic [ADDR_W-1:0] regaAddr,
  input  logic              regbRd,
  input  logic [ADDR_W-1:0] regbAddr,
  output logic [DATA_W-1:0] regaData,
  output logic [DATA_W-1:0] regbData,
  output logic [DATA_W-1:0] wbData,
  output logic [ADDR_W-1:0] wbAddr,
  output logic              wbWr,
  output logic [CNT_W-1:0]  wbCnt
);

  logic [DATA_W-1:0] wb_data_q;
  logic [ADDR_W-1:0] wb_addr_q;
  logic              wb_wr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              commit;
  logic [DATA_W-1:0] arr_a;
  logic [DATA_W-1:0] arr_b;
  rd_src_t           src_a;
  rd_src_t           src_b;

  // A latched write to r0 is neither stored nor counted.
  assign commit = wb_wr_q && (wb_addr_q != '0);

  wb_regfile_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (commit),
    .waddr   (wb_addr_q),
    .wdata   (wb_data_q),
    .raddr_a (regaAddr),
    .rdata_a (arr_a),
    .raddr_b (regbAddr),
    .rdata_b (arr_b)
  );

  // EX/WB latch: reset clears, stall holds, flush loads a dead write, else loads the EX result.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_data_q <= '0;
      wb_addr_q <= '0;
      wb_wr_q   <= `DISABLE;
    end else if (!stall) begin
      wb_data_q <= regcData;
      wb_addr_q <= regcAddr;
      wb_wr_q   <= flush ? `DISABLE : regcWr;
    end
  end

  // Commit counter; counts every commit cycle including re-commits while stalled, wraps silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (commit) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Operand read muxes with EX and WB bypass.
  always_comb begin
    src_a = sel_src(regaRd, regaAddr == '0, regcWr && (regcAddr == regaAddr),
                    wb_wr_q && (wb_addr_q == regaAddr));
    src_b = sel_src(regbRd, regbAddr == '0, regcWr && (regcAddr == regbAddr),
                    wb_wr_q && (wb_addr_q == regbAddr));
    regaData = '0;
    regbData = '0;
    case (src_a)
      SRC_EX:  regaData = regcData;
      SRC_WB:  regaData = wb_data_q;
      SRC_ARR: regaData = arr_a;
      default: regaData = '0;
    endcase
    case (src_b)
      SRC_EX:  regbData = regcData;
      SRC_WB:  regbData = wb_data_q;
      SRC_ARR: regbData = arr_b;
      default: regbData = '0;
    endcase
  end

  assign wbData = wb_data_q;
  assign wbAddr = wb_addr_q;
  assign wbWr   = wb_wr_q;
  assign wbCnt  = cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios then randomized traffic against a register model.
// Timing: inputs change 1 time unit after the rising edge; outputs are compared mid-cycle.
// Model: architectural register array, one pending write and a commit count.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] regcData;
  logic [4:0]  regcAddr;
  logic        regcWr;
  logic        regaRd;
  logic [4:0]  regaAddr;
  logic        regbRd;
  logic [4:0]  regbAddr;
  logic [31:0] regaData;
  logic [31:0] regbData;
  logic [31:0] wbData;
  logic [4:0]  wbAddr;
  logic        wbWr;
  logic [31:0] wbCnt;

  int checks = 0;
  int errors = 0;

  // Reference state: committed registers, the pending (latched) write, commit count.
  logic [31:0] m_mem [32];
  logic [31:0] m_data;
  logic [4:0]  m_addr;
  logic        m_wr;
  logic [31:0] m_cnt;

  wb_regfile dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .regcData (regcData),
    .regcAddr (regcAddr),
    .regcWr   (regcWr),
    .regaRd   (regaRd),
    .regaAddr (regaAddr),
    .regbRd   (regbRd),
    .regbAddr (regbAddr),
    .regaData (regaData),
    .regbData (regbData),
    .wbData   (wbData),
    .wbAddr   (wbAddr),
    .wbWr     (wbWr),
    .wbCnt    (wbCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The value a reader should see given the current EX inputs and the model state.
  function automatic logic [31:0] ref_read(input logic rd, input logic [4:0] a);
    if (!rd || a == 5'd0) return 32'd0;
    if (regcWr && regcAddr == a) return regcData;
    if (m_wr && m_addr == a) return m_data;
    return m_mem[a];
  endfunction

  // Advance one clock, applying the architectural effect of that edge to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
      m_data = 32'd0;
      m_addr = 5'd0;
      m_wr   = 1'b0;
      m_cnt  = 32'd0;
    end else begin
      if (m_wr && m_addr != 5'd0) begin
        m_mem[m_addr] = m_data;
        m_cnt = m_cnt + 32'd1;
      end
      if (!stall) begin
        m_wr   = flush ? 1'b0 : regcWr;
        m_addr = regcAddr;
        m_data = regcData;
      end
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    #3;
    chk({tag, ".rdA"}, regaData, ref_read(regaRd, regaAddr));
    chk({tag, ".rdB"}, regbData, ref_read(regbRd, regbAddr));
    chk({tag, ".wbWr"}, {31'd0, wbWr}, {31'd0, m_wr});
    chk({tag, ".wbCnt"}, wbCnt, m_cnt);
    if (m_wr) begin
      chk({tag, ".wbAddr"}, {27'd0, wbAddr}, {27'd0, m_addr});
      chk({tag, ".wbData"}, wbData, m_data);
    end
  endtask

  task automatic ex(input logic wr, input logic [4:0] a, input logic [31:0] d);
    regcWr   = wr;
    regcAddr = a;
    regcData = d;
  endtask

  task automatic idle_drain();
    ex(1'b0, 5'd0, 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    tick();
    tick();
  endtask

  logic [31:0] cnt0;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
    m_data = 32'd0; m_addr = 5'd0; m_wr = 1'b0; m_cnt = 32'd0;
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    ex(1'b0, 5'd0, 32'd0);
    regaRd = 1'b1; regaAddr = 5'd1; regbRd = 1'b1; regbAddr = 5'd2;
    #1;
    tick();
    tick();
    rst = 1'b1;
    check_all("reset");
    chk("reset.wbWr0", {31'd0, wbWr}, 32'd0);
    chk("reset.cnt0", wbCnt, 32'd0);

    // Reset clears a committed register.
    ex(1'b1, 5'd5, 32'h1234);
    tick();
    ex(1'b0, 5'd0, 32'd0);
    tick();
    regaAddr = 5'd5;
    check_all("r5pre");
    chk("r5.committed", regaData, 32'h1234);
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    check_all("r5rst");
    chk("r5.cleared", regaData, 32'd0);
    chk("r5.cnt", wbCnt, 32'd0);

    // Basic commit through EX bypass, WB bypass, then array.
    ex(1'b1, 5'd3, 32'hDEADBEEF);
    regaAddr = 5'd3;
    check_all("basic.ex");
    chk("basic.exbyp", regaData, 32'hDEADBEEF);
    tick();
    ex(1'b0, 5'd0, 32'd0);
    check_all("basic.wb");
    chk("basic.wbbyp", regaData, 32'hDEADBEEF);
    tick();
    check_all("basic.arr");
    chk("basic.arr", regaData, 32'hDEADBEEF);
    chk("basic.cnt", wbCnt, 32'd1);
    tick();
    check_all("basic.arr2");

    // EX result beats the WB latch for the same register.
    ex(1'b1, 5'd7, 32'h11);
    tick();
    ex(1'b1, 5'd7, 32'h22);
    regbAddr = 5'd7;
    check_all("byp.ex");
    chk("byp.exwins", regbData, 32'h22);
    tick();
    ex(1'b0, 5'd0, 32'd0);
    check_all("byp.wb");
    chk("byp.wbval", regbData, 32'h22);
    idle_drain();

    // Writes to r0 are neither visible nor counted.
    cnt0 = wbCnt;
    ex(1'b1, 5'd0, 32'hFFFFFFFF);
    regaAddr = 5'd0;
    check_all("r0.ex");
    chk("r0.exzero", regaData, 32'd0);
    tick();
    ex(1'b0, 5'd0, 32'd0);
    check_all("r0.wb");
    tick();
    chk("r0.cnt", wbCnt, cnt0);
    chk("r0.read", regaData, 32'd0);

    // Stall holds the latch and re-commits every held cycle.
    ex(1'b1, 5'd4, 32'h55);
    tick();
    cnt0 = wbCnt;
    stall = 1'b1;
    ex(1'b1, 5'd8, 32'hAA);
    regaAddr = 5'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_all("stall");
    end
    chk("stall.data", wbData, 32'h55);
    chk("stall.addr", {27'd0, wbAddr}, 32'd4);
    chk("stall.cnt", wbCnt, cnt0 + 32'd3);
    stall = 1'b0;
    idle_drain();

    // Flush kills the write; r9 never reaches the array.
    ex(1'b1, 5'd9, 32'h99);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ex(1'b0, 5'd0, 32'd0);
    regaAddr = 5'd9;
    check_all("flush");
    chk("flush.wbWr", {31'd0, wbWr}, 32'd0);
    tick();
    tick();
    check_all("flush.arr");
    chk("flush.r9", regaData, 32'd0);

    // Counter wraps silently from all-ones.
    ex(1'b1, 5'd10, 32'h1);
    tick();
    ex(1'b0, 5'd0, 32'd0);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    m_cnt = 32'hFFFFFFFF;
    tick();
    check_all("wrap");
    chk("wrap.cnt", wbCnt, 32'd0);

    // Reset on the commit edge discards the pending write.
    ex(1'b1, 5'd6, 32'h66);
    tick();
    ex(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    regaAddr = 5'd6;
    check_all("midrst");
    chk("midrst.r6", regaData, 32'd0);
    tick();
    chk("midrst.r6b", regaData, 32'd0);

    // Randomized traffic, addresses biased to a small range to provoke bypass hits.
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) != 0);
      stall    = ($urandom_range(0, 5) == 0);
      flush    = ($urandom_range(0, 5) == 0);
      regcWr   = ($urandom_range(0, 3) != 0);
      regcAddr = 5'($urandom_range(0, 7));
      regcData = $urandom;
      regaRd   = ($urandom_range(0, 7) != 0);
      regbRd   = ($urandom_range(0, 7) != 0);
      regaAddr = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      regbAddr = ($urandom_range(0, 3) == 0) ? regaAddr : 5'($urandom_range(0, 7));
      if (rst) check_all("rand.pre");
      tick();
      if (rst) check_all("rand.post");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
